// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared width constant and control-strobe bundle for the multiplier
package mul_pkg;

  localparam int MUL_W = 16;

  typedef struct packed {
    logic lda;
    logic ldb;
    logic ldp;
    logic clrp;
    logic decb;
  } mul_ctrl_t;

endpackage

// File: rtl/mul_down_counter.sv
// rtl/mul_down_counter.sv - loadable down counter that saturates at zero
import mul_pkg::*;

module mul_down_counter #(
  parameter int W = MUL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         zero
);

  assign zero = (q == '0);

  // Load beats decrement; decrement never wraps past zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (dec && !zero) begin
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/mul_datapath.sv
// rtl/mul_datapath.sv - repeated-addition multiplier datapath (A, B counter, P); MUL_DP_OVF_EN adds sticky overflow
import mul_pkg::*;

module mul_datapath #(
  parameter int W = MUL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic         lda,
  input  logic         ldb,
  input  logic         ldp,
  input  logic         clrp,
  input  logic         decb,
  output logic         done,
  output logic [W-1:0] product,
  output logic         ovf
);

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;

  assign product = p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
    end else if (lda) begin
      a <= data_in;
    end
  end

  mul_down_counter #(.W(W)) u_b (
    .clk  (clk),
    .rst  (rst),
    .load (ldb),
    .dec  (decb),
    .din  (data_in),
    .q    (b),
    .zero (done)
  );

  // The B != 0 gate swallows the controller's trailing add after done rises.
`ifdef MUL_DP_OVF_EN
  logic [W:0] sum;
  assign sum = {1'b0, p} + {1'b0, a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (clrp) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (ldp && !done) begin
      p <= sum[W-1:0];
      if (sum[W]) begin
        ovf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (clrp) begin
      p <= '0;
    end else if (ldp && !done) begin
      p <= p + a;
    end
  end
`endif

endmodule

// File: doc/mul_datapath.md
# mul_datapath

Arithmetic datapath for the shift-free repeated-addition multiplier. Sits directly downstream of `mul_controlpath`: it consumes that block's `lda`, `ldb`, `ldp`, `clrp` and `decb` strobes, holds operand A, down-counter B and accumulator P, and returns `done` to the controller. It forms the multiplier core that the sequential environment's testbench drives, together with `mul_controlpath`.

## Interface
- `W`, 16: operand, counter and product width in bits.

- `clk`  in  1  rising-edge clock, shared with `mul_controlpath`.
- `rst`  in  1  reset; asynchronous, active-high.
- `data_in`  in  W  shared operand bus; sampled by `lda` and by `ldb`.
- `lda`  in  1  load A from `data_in`.
- `ldb`  in  1  load B from `data_in`.
- `ldp`  in  1  accumulate, P <= P + A.
- `clrp`  in  1  clear P and `ovf`.
- `decb`  in  1  decrement B.
- `done`  out  1  B == 0. Combinational from the B register only.
- `product`  out  W  current P register.
- `ovf`  out  1  sticky accumulator overflow (see Configuration).

## Operation
- Registers A, B and P are all W bits. All of them update on the rising edge of `clk`.
- A: when `lda`=1, A <= `data_in`. Otherwise A holds.
- B:
  - If `ldb`=1, B <= `data_in`. `ldb` takes priority over `decb`.
  - Else if `decb`=1 and B != 0, B <= B - 1.
  - B never wraps below 0.
- P:
  - If `clrp`=1, P <= 0. `clrp` takes priority over `ldp`.
  - Else if `ldp`=1 and B != 0, P <= P + A, truncated to W bits.
- Gating by B != 0: the controller still asserts `ldp`/`decb` on the edge at which it leaves its accumulate state, after `done` has already risen. The gate blocks that extra add. It also gives P = 0 when B is loaded with 0.
- `done` = (B == 0). No registering and no dependence on the strobes.
- Any combination of strobes is legal, including all five asserted together. The priorities above fully resolve every case.
- A normal product sequence, as driven by `mul_controlpath`:
  1. `lda` with A on `data_in`.
  2. `ldb`+`clrp` with B on `data_in`.
  3. `ldp`+`decb` repeated until `done`.
  4. Result: `product` = (A*B) mod 2^W.

## Timing
- Reset values (asynchronous, take effect immediately): A=0, B=0, P=0, `ovf`=0. As a consequence, `done`=1 and `product`=0.
- Reset asserted mid-operation: all registers clear immediately. The accumulation in progress is abandoned. No state survives deassertion.
- Load latency: a value on `data_in` is visible in A or B one edge after the strobe.
- `done` latency:
  - `done` changes in the same cycle as B, i.e. zero cycles after the B update edge.
  - With B loaded to N >= 1, `done` rises after exactly N accumulate edges.
  - On that final edge, P holds A*N (mod 2^W).
- `product` reflects P directly, with no output register.

## Configuration
- Macro: `MUL_DP_OVF_EN`.
- Defined:
  - `ovf` is set on any gated accumulate where the W-bit add produces a carry out.
  - Once set, `ovf` stays set until `clrp` or `rst`.
  - If `clrp` and an overflowing add occur in the same cycle, `clrp` wins and `ovf` is 0.
- Undefined:
  - `ovf` is tied to 0.
  - No carry logic is generated.
  - P wraps silently.

## Structure
- Shared package `mul_pkg`:
  - default width constant `MUL_W` = 16;
  - typedef `mul_ctrl_t`, a packed struct {lda, ldb, ldp, clrp, decb} for bench and controller binding.
- One sub-module, `mul_down_counter`:
  - parameter W;
  - ports: load, dec, din, q, zero;
  - implements B with load priority, decrement-stops-at-zero, and the `zero` output.
- The top level instantiates `mul_down_counter` and holds A, P and `ovf` inline.

## Test plan
- W=16. Sequence `lda` `data_in`=7; `ldb`+`clrp` `data_in`=5; hold `ldp`+`decb` for 6 edges. Expected: `done` rises after the 5th edge, and `product`=35 stays at 35 on the 6th edge (gating).
- B=0: `lda` 9; `ldb`+`clrp` 0; `ldp`+`decb` for 3 edges. Expected: `done`=1 throughout and `product`=0.
- Priority: with P=12 and B=3, assert `clrp`+`ldp`+`ldb`(`data_in`=4)+`decb` in the same cycle. Expected next cycle: P=0 and B=4.
- Overflow, W=8, `MUL_DP_OVF_EN` defined: A=200, B=2, run to `done`. Expected: `product`=144 and `ovf`=1. A following `clrp` gives `ovf`=0.
- Same stimulus as the previous case with the macro undefined. Expected: `product`=144 and `ovf`=0.
- Reset mid-operation: A=10, B=6; assert `rst` asynchronously after 3 accumulate edges (P=30). Expected, immediately: A=B=P=0, `done`=1, `ovf`=0. Expected after deassertion: further `ldp`/`decb` leave P=0.
